// File: rtl/pulse_decoder.sv
// pulse_decoder
//   Receive-side decoder for the active-low framing waveform (idle high,
//   periodic low pulse). Synchronises the asynchronous line, measures the
//   low-pulse width and the fall-to-fall period of each frame, qualifies
//   each frame against the expected shape and declares lock after a run of
//   matching frames. A frame with no edge for TIMEOUT cycles is aborted.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   f          in   incoming waveform, asynchronous to clock
//   period     out  last measured fall-to-fall period (cycles)
//   low_width  out  last measured low width (cycles)
//   valid      out  one-cycle strobe when period/low_width update
//   match      out  frame within tolerance; qualifies valid
//   locked     out  LOCK_COUNT consecutive matching frames seen
//   timeout    out  one-cycle strobe when a measurement is aborted
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first fall; counter held at 0
// LOW   | line low since the last fall; counting toward the rise
// HIGH  | line high after the rise; counting toward the next fall
module pulse_decoder #(
    parameter int WIDTH      = 10,
    parameter int EXP_PERIOD = 500,
    parameter int EXP_LOW    = 70,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             f,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] low_width,
    output logic             valid,
    output logic             match,
    output logic             locked,
    output logic             timeout
);

    localparam int MRUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH:0]    EXP_P_X   = (WIDTH+1)'(EXP_PERIOD);
    localparam logic [WIDTH:0]    EXP_L_X   = (WIDTH+1)'(EXP_LOW);
    localparam logic [WIDTH:0]    TOL_X     = (WIDTH+1)'(TOL);
    localparam logic [WIDTH-1:0]  TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0]  CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [MRUN_W-1:0] LOCK_C    = MRUN_W'(LOCK_COUNT);
    localparam logic [MRUN_W-1:0] MRUN_ONE  = MRUN_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, fd_q;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  lw_q, lw_d;
    logic [WIDTH-1:0]  period_q, period_d;
    logic [WIDTH-1:0]  low_q, low_d;
    logic              valid_q, valid_d;
    logic              match_q, match_d;
    logic              locked_q, locked_d;
    logic              timeout_q, timeout_d;
    logic [MRUN_W-1:0] mrun_q, mrun_d;

    logic             fall, rise;
    logic [WIDTH-1:0] cnt_inc;
    logic             frame_ok;

    // Absolute deviation in WIDTH+1 bits, subtracting in whichever order
    // keeps the result non-negative so nothing wraps.
    function automatic logic within_tol(input logic [WIDTH-1:0] meas,
                                        input logic [WIDTH:0]   expv);
        logic [WIDTH:0] m;
        logic [WIDTH:0] d;
        m = {1'b0, meas};
        d = (m >= expv) ? (m - expv) : (expv - m);
        return (d <= TOL_X);
    endfunction

    assign fall = fd_q & ~s2_q;
    assign rise = ~fd_q & s2_q;

    // The counter holds at all-ones rather than wrapping; this only matters
    // when a rise lands exactly on the timeout count.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    assign frame_ok = within_tol(cnt_q, EXP_P_X) && within_tol(lw_q, EXP_L_X);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            fd_q      <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            lw_q      <= '0;
            period_q  <= '0;
            low_q     <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            mrun_q    <= '0;
        end else begin
            s1_q      <= f;
            s2_q      <= s1_q;
            fd_q      <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lw_q      <= lw_d;
            period_q  <= period_d;
            low_q     <= low_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            mrun_q    <= mrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lw_d      = lw_q;
        period_d  = period_q;
        low_d     = low_q;
        valid_d   = 1'b0;
        match_d   = match_q;
        timeout_d = 1'b0;
        mrun_d    = mrun_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    cnt_d   = CNT_ONE;
                    state_d = LOW;
                end
            end
            LOW: begin
                cnt_d = cnt_inc;
                if (rise) begin
                    lw_d    = cnt_q;
                    state_d = HIGH;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mrun_d    = '0;
                end
            end
            HIGH: begin
                cnt_d = cnt_inc;
                if (fall) begin
                    period_d = cnt_q;
                    low_d    = lw_q;
                    valid_d  = 1'b1;
                    match_d  = frame_ok;
                    cnt_d    = CNT_ONE;
                    state_d  = LOW;
                    if (frame_ok) begin
                        mrun_d = (mrun_q == LOCK_C) ? mrun_q : (mrun_q + MRUN_ONE);
                    end else begin
                        mrun_d = '0;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mrun_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Lock tracks the run counter it is registered alongside, so it
        // drops in the same cycle a mismatching valid or a timeout appears.
        locked_d = (mrun_d == LOCK_C);
    end

    assign period    = period_q;
    assign low_width = low_q;
    assign valid     = valid_q;
    assign match     = match_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pulse_decoder.sv
module tb_pulse_decoder;

    localparam int WIDTH      = 10;
    localparam int EXP_PERIOD = 500;
    localparam int EXP_LOW    = 70;
    localparam int TOL        = 2;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 1023;
    localparam int LAT        = 3;   // pin change to registered result, in edges

    logic             clock = 1'b0;
    logic             reset_n;
    logic             f;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] low_width;
    logic             valid;
    logic             match;
    logic             locked;
    logic             timeout;

    pulse_decoder #(
        .WIDTH      (WIDTH),
        .EXP_PERIOD (EXP_PERIOD),
        .EXP_LOW    (EXP_LOW),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .f         (f),
        .period    (period),
        .low_width (low_width),
        .valid     (valid),
        .match     (match),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit is_to;
        int t;
        int p;
        int l;
        bit m;
        bit lk;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: frame-level bookkeeping only.
    bit armed   = 0;   // a completed earlier frame is waiting for its closing fall
    int prev_l  = 0;
    int prev_p  = 0;
    int run_m   = 0;
    int last_p  = 0;
    int last_l  = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic bit in_tol(input int meas, input int expv);
        int d;
        d = meas - expv;
        if (d < 0) d = -d;
        return d <= TOL;
    endfunction

    // Bookkeeping for a fall on the pin at the current cycle, for a frame of
    // L low cycles followed by H high cycles.
    task automatic model_fall(input int L, input int H);
        exp_t e;
        bit   ok;
        int   t0;
        t0 = cyc;
        if (armed) begin
            ok    = in_tol(prev_p, EXP_PERIOD) && in_tol(prev_l, EXP_LOW);
            run_m = ok ? ((run_m < LOCK_COUNT) ? run_m + 1 : run_m) : 0;
            e     = '{0, t0 + LAT, prev_p, prev_l, ok, (run_m == LOCK_COUNT)};
            sb.push_back(e);
            last_p = prev_p;
            last_l = prev_l;
        end
        if (L > TIMEOUT || L + H > TIMEOUT) begin
            run_m = 0;
            e     = '{1, t0 + LAT + TIMEOUT, last_p, last_l, 0, 0};
            sb.push_back(e);
            armed = 0;
        end else begin
            armed  = 1;
            prev_l = L;
            prev_p = L + H;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge L+H cycles on.
    task automatic frame(input int L, input int H);
        model_fall(L, H);
        f = 1'b0;
        repeat (L) @(posedge clock);
        #1 f = 1'b1;
        repeat (H) @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},    int'(period),    0);
        check({tag, "_low_width"}, int'(low_width), 0);
        check({tag, "_valid"},     int'(valid),     0);
        check({tag, "_match"},     int'(match),     0);
        check({tag, "_locked"},    int'(locked),    0);
        check({tag, "_timeout"},   int'(timeout),   0);
    endtask

    // Scoreboard monitor: pops one expectation per output strobe.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && (valid || timeout)) begin
            check("strobe_exclusive", int'(valid && timeout), 0);
            check("sb_has_expectation", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("event_kind_is_timeout", int'(timeout), int'(e.is_to));
                check("event_cycle", cyc, e.t);
                check("period", int'(period), e.p);
                check("low_width", int'(low_width), e.l);
                check("locked", int'(locked), int'(e.lk));
                if (!e.is_to) check("match", int'(match), int'(e.m));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int L;
        int P;

        reset_n = 1'b0;
        f       = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Nominal frames from reset: first valid at the second fall, lock on 4th.
        repeat (6) frame(70, 430);

        // Tolerance edges after lock.
        frame(72, 426);
        frame(72, 430);
        frame(72, 431);
        repeat (5) frame(70, 430);

        // Low width outside tolerance, then relock.
        frame(73, 427);
        repeat (5) frame(70, 430);

        // Longest accepted period: fall lands exactly on the timeout count.
        frame(70, 953);
        repeat (5) frame(70, 430);

        // Stuck high after one fall: abort, then the next fall must not report.
        frame(70, 1200);
        repeat (5) frame(70, 430);

        // Random frames: half near nominal, half anywhere below the timeout.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                L = $urandom_range(74, 66);
                P = $urandom_range(504, 496);
            end else begin
                L = $urandom_range(200, 1);
                P = L + $urandom_range(700, 1);
            end
            frame(L, P - L);
        end

        // One-cycle glitch followed by a fall ten cycles later.
        frame(1, 9);
        frame(70, 430);

        // Reset in the middle of a low phase, with the line still low at release.
        model_fall(40, 460);
        f = 1'b0;
        repeat (20) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("midlow_reset");
        armed  = 0;
        run_m  = 0;
        last_p = 0;
        last_l = 0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        frame(30, 470);
        frame(70, 430);
        frame(70, 430);
        frame(70, 1200);

        for (int i = 0; i < 3000 && sb.size() > 0; i++) @(posedge clock);
        #1;
        check("sb_empty_at_end", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
